// File: rtl/reg_read_port.sv
// reg_read_port: sampled-register FIFO that buffers captured words for a consumer.
// Optional sticky drop flag enabled by defining READ_PORT_OVF_FLAG_EN.
module reg_read_port #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    iclk,
    input  logic                    irst_n,
    input  logic                    ireq,
    input  logic [DATA_WIDTH-1:0]   idata,
    input  logic                    iready,
    output logic                    ovalid,
    output logic [DATA_WIDTH-1:0]   odata,
    output logic                    ofull,
    output logic [$clog2(DEPTH):0]  ocount,
    output logic                    ooverflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           wptr_q, wptr_d;
    logic [AW-1:0]           rptr_q, rptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    push;
    logic                    pop;

    // A pop frees a slot in the same edge, so FULL still accepts a paired push.
    assign pop  = (state_q != EMPTY) && iready;
    assign push = ireq && ((state_q != FULL) || pop);

    // Next pointers, count and the occupancy state derived from that count.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        state_d = state_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (count_d == '0) begin
            state_d = EMPTY;
        end else if (count_d == CW'(DEPTH)) begin
            state_d = FULL;
        end else begin
            state_d = PARTIAL;
        end
    end

    // Control registers; reset discards every held entry at once.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= EMPTY;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Storage is left unreset; odata masks it while nothing is held.
    always_ff @(posedge iclk) begin
        if (push) begin
            mem_q[wptr_q] <= idata;
        end
    end

    assign ovalid = (count_q != '0);
    assign ofull  = (count_q == CW'(DEPTH));
    assign ocount = count_q;
    assign odata  = ovalid ? mem_q[rptr_q] : '0;

`ifdef READ_PORT_OVF_FLAG_EN
    logic ovf_q;

    // Sticky record that some request found no room.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ovf_q <= 1'b0;
        end else if (ireq && !push) begin
            ovf_q <= 1'b1;
        end
    end

    assign ooverflow = ovf_q;
`else
    assign ooverflow = 1'b0;
`endif

endmodule

// File: tb/tb_reg_read_port.sv
// tb_reg_read_port: directed stimulus with a queue scoreboard for reg_read_port.
// Expected drop-flag value follows READ_PORT_OVF_FLAG_EN.
module tb_reg_read_port;

    logic        iclk;
    logic        irst_n;
    logic        ireq;
    logic [15:0] idata;
    logic        iready;
    logic        ovalid;
    logic [15:0] odata;
    logic        ofull;
    logic [2:0]  ocount;
    logic        ooverflow;

    int pass_cnt;
    int total_cnt;
    logic [15:0] exp_q[$];
    logic ovf_exp;

    reg_read_port #(.DATA_WIDTH(16), .DEPTH(4)) dut (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .ireq      (ireq),
        .idata     (idata),
        .iready    (iready),
        .ovalid    (ovalid),
        .odata     (odata),
        .ofull     (ofull),
        .ocount    (ocount),
        .ooverflow (ooverflow)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, optionally expect the word to be stored.
    task automatic cyc(input logic req, input logic [15:0] d, input logic rdy, input logic acc);
        ireq   = req;
        idata  = d;
        iready = rdy;
        if (acc) exp_q.push_back(d);
        @(posedge iclk);
        #1;
    endtask

    // Monitor: a handshake seen between edges is consumed at the next edge.
    always @(negedge iclk) begin
        if (irst_n && ovalid && iready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL pop_unexpected: got %0h expected none", odata);
            end else begin
                chk("pop_data", {16'h0, odata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
`ifdef READ_PORT_OVF_FLAG_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        irst_n = 1'b0;
        ireq   = 1'b0;
        idata  = '0;
        iready = 1'b0;
        #22;
        chk("rst_ovalid", {31'h0, ovalid}, 0);
        chk("rst_ocount", {29'h0, ocount}, 0);
        chk("rst_ofull", {31'h0, ofull}, 0);
        chk("rst_ovf", {31'h0, ooverflow}, 0);
        chk("rst_odata", {16'h0, odata}, 0);
        irst_n = 1'b1;
        @(posedge iclk);
        #1;

        cyc(1'b1, 16'hA5A5, 1'b0, 1'b1);
        chk("lat_ovalid", {31'h0, ovalid}, 1);
        chk("lat_odata", {16'h0, odata}, 32'hA5A5);
        chk("lat_ocount", {29'h0, ocount}, 1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("drain1_ocount", {29'h0, ocount}, 0);

        for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i), 1'b0, 1'b1);
        chk("full_ofull", {31'h0, ofull}, 1);
        chk("full_ocount", {29'h0, ocount}, 4);

        cyc(1'b1, 16'h00FF, 1'b0, 1'b0);
        chk("drop_ocount", {29'h0, ocount}, 4);
        chk("drop_ovf", {31'h0, ooverflow}, {31'h0, ovf_exp});
        chk("drop_head", {16'h0, odata}, 1);

        cyc(1'b1, 16'h0005, 1'b1, 1'b1);
        chk("fullpp_ocount", {29'h0, ocount}, 4);
        chk("fullpp_head", {16'h0, odata}, 2);

        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("drain4_ovalid", {31'h0, ovalid}, 0);
        chk("drain4_ocount", {29'h0, ocount}, 0);
        chk("drain4_odata", {16'h0, odata}, 0);
        chk("ovf_sticky", {31'h0, ooverflow}, {31'h0, ovf_exp});

        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 16'(i), 1'b1, 1'b1);
            chk("stream_ocount", {29'h0, ocount}, 1);
        end
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("stream_end", {29'h0, ocount}, 0);

        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("underflow", {29'h0, ocount}, 0);

        cyc(1'b1, 16'h0007, 1'b0, 1'b1);
        cyc(1'b1, 16'h0008, 1'b0, 1'b1);
        cyc(1'b1, 16'h0009, 1'b0, 1'b1);
        chk("pre_rst_ocount", {29'h0, ocount}, 3);
        ireq = 1'b0;
        #2;
        irst_n = 1'b0;
        #1;
        chk("arst_ovalid", {31'h0, ovalid}, 0);
        chk("arst_ocount", {29'h0, ocount}, 0);
        chk("arst_ofull", {31'h0, ofull}, 0);
        chk("arst_ovf", {31'h0, ooverflow}, 0);
        exp_q.delete();
        @(negedge iclk);
        #1;
        irst_n = 1'b1;
        @(posedge iclk);
        #1;
        chk("post_rst_ocount", {29'h0, ocount}, 0);
        cyc(1'b1, 16'h1234, 1'b0, 1'b1);
        chk("post_rst_odata", {16'h0, odata}, 32'h1234);
        chk("post_rst_cnt", {29'h0, ocount}, 1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg_read_port.md
REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 Parameter DATA_WIDTH, default 16 (CPU_package value), width of sampled data word.
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, >= 2.
REQ-003 iclk  input  1  sole clock; all state updates on rising edge.
REQ-004 irst_n  input  1  reset, asynchronous, active-low.
REQ-005 ireq  input  1  sample request; when high at a clock edge, idata is captured if space exists.
REQ-006 idata  input  DATA_WIDTH  register contents to sample.
REQ-007 iready  input  1  downstream consumer ready.
REQ-008 ovalid  output  1  head entry available to consumer.
REQ-009 odata  output  DATA_WIDTH  head entry; stable while ovalid high and iready low.
REQ-010 ofull  output  1  buffer holds DEPTH entries.
REQ-011 ocount  output  $clog2(DEPTH)+1  number of entries held.
REQ-012 ooverflow  output  1  sticky flag: a request was dropped (see Configuration).

Function
REQ-013 Buffer is a circular FIFO, write pointer and read pointer each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-014 Control state SHALL be one of EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count DEPTH), derived from ocount.
REQ-015 Push: ireq high at edge and (not FULL, or pop in same cycle) -> idata written at write pointer, pointer advances.
REQ-016 Pop: ovalid and iready high at edge -> read pointer advances; entry consumed.
REQ-017 Simultaneous push and pop: count unchanged, both pointers advance; in FULL this push SHALL be accepted.
REQ-018 Push in FULL without pop: request dropped, contents and pointers unchanged.
REQ-019 Push in EMPTY: no bypass; ovalid rises after that edge, i.e. one-cycle latency from ireq to ovalid.
REQ-020 iready while EMPTY: no effect, count never underflows.
REQ-021 ovalid = (count != 0); ofull = (count == DEPTH); both combinational from registered count.
REQ-022 odata = buffer entry at read pointer; order strictly first-in first-out.
REQ-023 ovalid once high SHALL stay high until a pop occurs (no retraction).

Reset
REQ-024 irst_n low SHALL immediately clear pointers, ocount=0, ovalid=0, ofull=0, ooverflow=0, independent of iclk.
REQ-025 Buffer storage need not be reset; odata SHALL read 0 while EMPTY.
REQ-026 Reset asserted mid-operation SHALL discard all held entries; first edge after release behaves as from EMPTY.

Configuration
REQ-027 Macro READ_PORT_OVF_FLAG_EN defined: ooverflow set on the edge a request is dropped (REQ-018), held until reset.
REQ-028 Macro undefined: ooverflow port present but tied to 0; no overflow logic synthesized.

Verification
REQ-029 Reset then ireq=1, idata=16'hA5A5 one cycle, iready=0 -> next cycle ovalid=1, odata=16'hA5A5, ocount=1.
REQ-030 Push 16'h0001..16'h0004 (DEPTH=4), iready=0 -> ofull=1, ocount=4; then iready=1 four cycles -> odata 1,2,3,4 in order, ovalid=0 after.
REQ-031 FULL, ireq=1 idata=16'h00FF, iready=0 -> dropped, ocount=4; with READ_PORT_OVF_FLAG_EN ooverflow=1 until reset, without it ooverflow=0.
REQ-032 FULL, ireq=1 idata=16'h0005 and iready=1 same cycle -> ocount stays 4, head becomes 16'h0002, 16'h0005 emerges last.
REQ-033 Continuous ireq and iready for 10 cycles with idata=cycle index -> pointers wrap, ocount stays 1, output sequence matches input delayed one cycle.
REQ-034 ocount=3, assert irst_n=0 between edges -> ovalid, ocount, ofull, ooverflow drop to 0 immediately; after release push 16'h1234 -> odata=16'h1234.
